dma_bus_arbiter: RTL and testbench

- Shares the 68000 bus between the CPU and up to NUM_REQ DMA-capable masters (e.g. a future SPI-to-SRAM block-copy engine).
- Runs the BR/BG/BGACK bus-request handshake with the CPU and grants the bus round-robin to one requester at a time.
- Optionally limits how long one requester can hold the bus.
- Sits beside the bus controller and reuses its clock, reset and strobe conventions. All bus strobes here are active-high; pin inversion happens at the top level.

---
 rtl/dma_arb_pkg.sv | 21 ++
 rtl/rr_priority_picker.sv | 31 +++
 rtl/dma_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dma_bus_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// rtl/dma_arb_pkg.sv - shared constants and helpers for the DMA bus arbiter
package dma_arb_pkg;

  // FSM state encoding
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] REQUEST  = 3'd1;
  localparam logic [2:0] WAIT_BUS = 3'd2;
  localparam logic [2:0] OWNED    = 3'd3;
  localparam logic [2:0] RELEASE  = 3'd4;

  // Default configuration
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_MAX_TENURE = 64;
  localparam int DEF_BG_TIMEOUT = 255;

  // Width of an index into n requesters (at least one bit)
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker, search starts after ptr
module rr_priority_picker
  import dma_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // Walk ptr+1, ptr+2, ... modulo N and take the first set request
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - 68000 BR/BG/BGACK arbiter for DMA masters; optional DMA_ARB_TENURE_LIMIT_EN
module dma_bus_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_TENURE = DEF_MAX_TENURE,
  parameter int BG_TIMEOUT = DEF_BG_TIMEOUT
) (
  input  logic                          CPUCLK_IN,
  input  logic                          RUN_IN,
  input  logic [NUM_REQ-1:0]            REQ_IN,
  output logic [NUM_REQ-1:0]            GNT_OUT,
  output logic                          REVOKE_OUT,
  output logic [idx_width(NUM_REQ)-1:0] OWNER_OUT,
  output logic                          BR_OUT,
  input  logic                          BG_IN,
  output logic                          BGACK_OUT,
  input  logic                          AS_IN,
  input  logic                          DTACK_IN,
  output logic                          BUSY_OUT,
  output logic                          BG_TIMEOUT_OUT,
  input  logic                          CLEAR_ERR_IN
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int BW = $clog2(BG_TIMEOUT) + 1;
  localparam logic [BW-1:0] BG_MAX  = BW'(BG_TIMEOUT);
  localparam logic [BW-1:0] BG_LAST = BW'(BG_TIMEOUT - 1);

  // Reject configurations outside the supported range at elaboration
  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_TENURE < 2 || BG_TIMEOUT < 1) begin : g_bad_cfg
    $error("dma_bus_arbiter: unsupported parameter set");
  end

  logic [2:0]         state;
  logic [IW-1:0]      ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               br_q;
  logic               bgack_q;
  logic               err_q;
  logic [BW-1:0]      bg_cnt;

  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               bg_expired;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req    (REQ_IN),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Abort the request on the edge that would take the wait count to BG_TIMEOUT;
  // BG and a withdrawn request both take precedence over the timeout
  always_comb begin
    bg_expired = 1'b0;
    if (state == REQUEST && !BG_IN && (|REQ_IN) && (bg_cnt >= BG_LAST))
      bg_expired = 1'b1;
  end

  // Main handshake FSM: BR/BG/BGACK sequencing, grant and round-robin pointer
  always_ff @(negedge CPUCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      state   <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      gnt_q   <= '0;
      br_q    <= 1'b0;
      bgack_q <= 1'b0;
      bg_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|REQ_IN) begin
            state  <= REQUEST;
            br_q   <= 1'b1;
            bg_cnt <= '0;
          end
        end
        REQUEST: begin
          if (BG_IN) begin
            state <= WAIT_BUS;
          end else if (!(|REQ_IN)) begin
            state <= IDLE;
            br_q  <= 1'b0;
          end else if (bg_expired) begin
            state <= IDLE;
            br_q  <= 1'b0;
          end else if (bg_cnt != BG_MAX) begin
            bg_cnt <= bg_cnt + 1'b1;
          end
        end
        WAIT_BUS: begin
          if (!AS_IN && !DTACK_IN) begin
            br_q <= 1'b0;
            if (pick_valid) begin
              state   <= OWNED;
              bgack_q <= 1'b1;
              gnt_q   <= pick_onehot;
              ptr_q   <= pick_idx;
            end else begin
              state <= IDLE;
            end
          end
        end
        OWNED: begin
          if (!REQ_IN[ptr_q]) begin
            state <= RELEASE;
            gnt_q <= '0;
          end
        end
        RELEASE: begin
          if (!AS_IN) begin
            state   <= IDLE;
            bgack_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          gnt_q   <= '0;
          br_q    <= 1'b0;
          bgack_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky BG timeout flag; a new timeout beats a simultaneous clear
  always_ff @(negedge CPUCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN)
      err_q <= 1'b0;
    else if (bg_expired)
      err_q <= 1'b1;
    else if (CLEAR_ERR_IN)
      err_q <= 1'b0;
  end

`ifdef DMA_ARB_TENURE_LIMIT_EN
  localparam int TW = $clog2(MAX_TENURE) + 1;
  localparam logic [TW-1:0] TEN_MAX  = TW'(MAX_TENURE);
  localparam logic [TW-1:0] TEN_TRIP = TW'(MAX_TENURE - 1);

  logic [TW-1:0] tenure_cnt;
  logic          revoke_q;
  logic          competitor;

  assign competitor = |(REQ_IN & ~gnt_q);

  // Tenure counter and revoke request; both held clear outside OWNED
  always_ff @(negedge CPUCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      tenure_cnt <= '0;
      revoke_q   <= 1'b0;
    end else if (state != OWNED || !REQ_IN[ptr_q]) begin
      tenure_cnt <= '0;
      revoke_q   <= 1'b0;
    end else begin
      if (tenure_cnt != TEN_MAX)
        tenure_cnt <= tenure_cnt + 1'b1;
      if (tenure_cnt >= TEN_TRIP && competitor)
        revoke_q <= 1'b1;
    end
  end

  assign REVOKE_OUT = revoke_q;
`else
  assign REVOKE_OUT = 1'b0;
`endif

  assign GNT_OUT        = gnt_q;
  assign OWNER_OUT      = ptr_q;
  assign BR_OUT         = br_q;
  assign BGACK_OUT      = bgack_q;
  assign BUSY_OUT       = (state != IDLE);
  assign BG_TIMEOUT_OUT = err_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb/tb_dma_bus_arbiter.sv - directed self-checking bench for dma_bus_arbiter
module tb_dma_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       revoke;
  logic [1:0] owner;
  logic       br;
  logic       bg;
  logic       bgack;
  logic       as_i;
  logic       dtack;
  logic       busy;
  logic       bg_err;
  logic       clr;
  logic       cpu_auto;

  int checks = 0;
  int errors = 0;

  dma_bus_arbiter #(
    .NUM_REQ    (4),
    .MAX_TENURE (8),
    .BG_TIMEOUT (255)
  ) dut (
    .CPUCLK_IN      (clk),
    .RUN_IN         (rst_n),
    .REQ_IN         (req),
    .GNT_OUT        (gnt),
    .REVOKE_OUT     (revoke),
    .OWNER_OUT      (owner),
    .BR_OUT         (br),
    .BG_IN          (bg),
    .BGACK_OUT      (bgack),
    .AS_IN          (as_i),
    .DTACK_IN       (dtack),
    .BUSY_OUT       (busy),
    .BG_TIMEOUT_OUT (bg_err),
    .CLEAR_ERR_IN   (clr)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // CPU model: answers BR with BG half a cycle later
  always @(posedge clk) if (cpu_auto) bg = br;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(input int limit, output logic br_seen);
    br_seen = 1'b0;
    for (int i = 0; i < limit && gnt == 4'b0000; i++) begin
      step();
      if (br) br_seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    step();
  endtask

  logic seen;
  logic exp_rev;

  initial begin
    rst_n = 1'b0; req = 4'b0; bg = 1'b0; as_i = 1'b0; dtack = 1'b0;
    clr = 1'b0; cpu_auto = 1'b0;
    step(); step();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_br", br, 0);
    chk("rst_bgack", bgack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", bg_err, 0);
    chk("rst_owner", owner, 3);
    chk("rst_revoke", revoke, 0);
    rst_n = 1'b1;

    // Single requester, 3-edge latency and release sequence
    cpu_auto = 1'b1;
    req = 4'b0001;
    step();
    chk("t1_br_e1", br, 1);
    chk("t1_busy_e1", busy, 1);
    chk("t1_gnt_e1", gnt, 0);
    step();
    chk("t1_gnt_e2", gnt, 0);
    chk("t1_bgack_e2", bgack, 0);
    step();
    chk("t1_gnt_e3", gnt, 4'b0001);
    chk("t1_bgack_e3", bgack, 1);
    chk("t1_br_e3", br, 0);
    chk("t1_owner_e3", owner, 0);
    req = 4'b0000;
    step();
    chk("t1_gnt_drop", gnt, 0);
    chk("t1_bgack_rel", bgack, 1);
    step();
    chk("t1_bgack_off", bgack, 0);
    chk("t1_busy_off", busy, 0);

    // Round robin with all four requesting
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(12, seen);
      chk($sformatf("rr_gnt_%0d", k), gnt, 32'(1 << (k % 4)));
      chk($sformatf("rr_br_%0d", k), seen, 1);
      step(); step(); step();
      chk($sformatf("rr_hold_%0d", k), gnt, 32'(1 << (k % 4)));
      req[k % 4] = 1'b0;
      step();
      chk($sformatf("rr_drop_%0d", k), gnt, 0);
      req = 4'b1111;
    end

    // BG arrives while the CPU still drives AS
    do_reset();
    req = 4'b0000;
    step();
    as_i = 1'b1;
    req = 4'b0001;
    step(); step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("as_hold_%0d", k), bgack, 0);
    end
    as_i = 1'b0; dtack = 1'b1;
    step();
    chk("dtack_hold", bgack, 0);
    dtack = 1'b0;
    step();
    chk("as_free_bgack", bgack, 1);
    chk("as_free_gnt", gnt, 4'b0001);
    req = 4'b0000;
    step(); step();

    // BG never arrives
    do_reset();
    cpu_auto = 1'b0; bg = 1'b0;
    req = 4'b0010;
    step();
    chk("to_br_on", br, 1);
    for (int k = 0; k < 254; k++) step();
    chk("to_err_early", bg_err, 0);
    chk("to_br_early", br, 1);
    step();
    chk("to_err_set", bg_err, 1);
    chk("to_br_off", br, 0);
    chk("to_busy_off", busy, 0);
    req = 4'b0000;
    step();
    chk("to_err_sticky", bg_err, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("to_err_clr", bg_err, 0);

    // Tenure limit with a competing requester
`ifdef DMA_ARB_TENURE_LIMIT_EN
    exp_rev = 1'b1;
`else
    exp_rev = 1'b0;
`endif
    do_reset();
    cpu_auto = 1'b1;
    req = 4'b0101;
    wait_grant(12, seen);
    chk("ten_gnt0", gnt, 4'b0001);
    for (int k = 0; k < 7; k++) step();
    chk("ten_rev_early", revoke, 0);
    step();
    chk("ten_rev", revoke, exp_rev);
    req = 4'b0100;
    step();
    chk("ten_drop_gnt", gnt, 0);
    chk("ten_drop_rev", revoke, 0);
    wait_grant(12, seen);
    chk("ten_gnt2", gnt, 4'b0100);
    chk("ten_owner2", owner, 2);

    // Asynchronous reset while requester 2 owns the bus
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt", gnt, 0);
    chk("ar_bgack", bgack, 0);
    chk("ar_br", br, 0);
    chk("ar_owner", owner, 3);
    req = 4'b1111;
    #1 rst_n = 1'b1;
    wait_grant(12, seen);
    chk("ar_first_gnt", gnt, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
